flags_ctx: RTL and testbench



---
 rtl/flags_pkg.sv | 23 ++
 rtl/flags_ctx_if.sv | 53 +++++
 rtl/flags_lifo.sv | 61 ++++++
 rtl/flags_ctx.sv | 99 +++++++++
 tb/tb_flags_ctx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/flags_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flags_pkg
// Brief    : Flag bit indices, default sizing and helpers for flags_ctx.
// Revision : 1.0 - initial release
// ============================================================================
package flags_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam int DEF_NUM_FLAGS   = 4;
  localparam int DEF_STACK_DEPTH = 4;

  // Depth counter must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flags_ctx_if.sv
`default_nettype none
// ============================================================================
// Module   : flags_ctx_if
// Brief    : Bus between ALU/control/interrupt logic and flags_ctx.
//            FLAGS_CTX_STICKY_EN adds the sticky_clr / sticky pair.
// Revision : 1.0 - initial release
// ============================================================================
interface flags_ctx_if
  import flags_pkg::*;
#(
  parameter int NUM_FLAGS   = DEF_NUM_FLAGS,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) ();
  localparam int CNT_W = cnt_width(STACK_DEPTH);

  logic                 load_flags;
  logic [NUM_FLAGS-1:0] flag_mask;
  logic [NUM_FLAGS-1:0] flags_in;
  logic                 wr_en;
  logic [NUM_FLAGS-1:0] wr_data;
  logic                 push;
  logic                 pop;
  logic                 err_clr;
  logic [NUM_FLAGS-1:0] flags;
  logic [CNT_W-1:0]     depth;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 stack_err;
`ifdef FLAGS_CTX_STICKY_EN
  logic                 sticky_clr;
  logic [NUM_FLAGS-1:0] sticky;
`endif

  modport master (
    output load_flags, flag_mask, flags_in, wr_en, wr_data, push, pop, err_clr,
`ifdef FLAGS_CTX_STICKY_EN
    output sticky_clr,
    input  sticky,
`endif
    input  flags, depth, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  load_flags, flag_mask, flags_in, wr_en, wr_data, push, pop, err_clr,
`ifdef FLAGS_CTX_STICKY_EN
    input  sticky_clr,
    output sticky,
`endif
    output flags, depth, stack_full, stack_empty, stack_err
  );

endinterface
`default_nettype wire

// File: rtl/flags_lifo.sv
`default_nettype none
// ============================================================================
// Module   : flags_lifo
// Brief    : Context LIFO; push/pop must already be qualified by the caller.
// Revision : 1.0 - initial release
// ============================================================================
module flags_lifo
  import flags_pkg::*;
#(
  parameter  int WIDTH = DEF_NUM_FLAGS,
  parameter  int DEPTH = DEF_STACK_DEPTH,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] depth_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push_i) begin
      depth_q <= depth_q + CNT_W'(1);
    end else if (pop_i) begin
      depth_q <= depth_q - CNT_W'(1);
    end
  end

  // Entry i is written when the stack currently holds exactly i contexts.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_i && (depth_q == CNT_W'(i))) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CNT_W'(i + 1)) begin
        rdata_o = mem_q[i];
      end
    end
  end

  assign depth_o = depth_q;
  assign full_o  = (depth_q == CNT_W'(DEPTH));
  assign empty_o = (depth_q == '0);

endmodule
`default_nettype wire

// File: rtl/flags_ctx.sv
`default_nettype none
// ============================================================================
// Module   : flags_ctx
// Brief    : Masked/writable status flags with an interrupt context LIFO.
//            Define FLAGS_CTX_STICKY_EN to add per-bit sticky capture.
// Revision : 1.0 - initial release
// ============================================================================
module flags_ctx
  import flags_pkg::*;
#(
  parameter int NUM_FLAGS   = DEF_NUM_FLAGS,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  flags_ctx_if.slave  bus
);
  localparam int CNT_W = cnt_width(STACK_DEPTH);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_FLAGS-1:0] w_loaded;
  logic [NUM_FLAGS-1:0] w_top;
  logic [CNT_W-1:0]     w_depth;
  logic                 w_full, w_empty;
  logic                 w_push_ok, w_pop_ok, w_err;
  logic                 err_q, err_d;

  assign w_push_ok = bus.push & ~bus.pop & ~w_full;
  assign w_pop_ok  = bus.pop & ~bus.push & ~w_empty;
  // Any requested stack operation that is not accepted is misuse.
  assign w_err     = (bus.push | bus.pop) & ~w_push_ok & ~w_pop_ok;

  flags_lifo #(
    .WIDTH (NUM_FLAGS),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push_ok),
    .pop_i   (w_pop_ok),
    .wdata_i (flags_q),
    .rdata_o (w_top),
    .depth_o (w_depth),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_load
    assign w_loaded[i] = bus.flag_mask[i] ? bus.flags_in[i] : flags_q[i];
  end

  always_comb begin
    flags_d = flags_q;
    if (w_pop_ok) begin
      flags_d = w_top;
    end else if (bus.wr_en) begin
      flags_d = bus.wr_data;
    end else if (bus.load_flags) begin
      flags_d = w_loaded;
    end
  end

  assign err_d = w_err | (err_q & ~bus.err_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

`ifdef FLAGS_CTX_STICKY_EN
  logic [NUM_FLAGS-1:0] sticky_q, sticky_d;

  assign sticky_d = (bus.sticky_clr ? '0 : sticky_q)
                  | (bus.flag_mask & bus.flags_in & {NUM_FLAGS{bus.load_flags}});

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.sticky = sticky_q;
`endif

  assign bus.flags       = flags_q;
  assign bus.depth       = w_depth;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.stack_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flags_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_flags_ctx
// Brief    : Self-checking bench for flags_ctx (FLAGS_CTX_STICKY_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flags_ctx;
  import flags_pkg::*;

  localparam int NF = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flags_ctx_if #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) bus ();

  flags_ctx #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_sticky;
  bit            m_err;
  logic [NF-1:0] m_stk [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic idle();
    reset          = 1'b0;
    bus.load_flags = 1'b0;
    bus.flag_mask  = '0;
    bus.flags_in   = '0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.err_clr    = 1'b0;
`ifdef FLAGS_CTX_STICKY_EN
    bus.sticky_clr = 1'b0;
`endif
  endtask

  // Reference: stack as a queue, flags as a plain value, rules applied in order.
  task automatic model_update();
    logic [NF-1:0] old;
    bit do_push, do_pop;
    if (reset) begin
      m_flags = '0; m_err = 0; m_sticky = '0; m_stk.delete();
      return;
    end
    do_push = bus.push && !bus.pop && (m_stk.size() < SD);
    do_pop  = bus.pop && !bus.push && (m_stk.size() > 0);
    old = m_flags;
    if (do_pop)              m_flags = m_stk.pop_back();
    else if (bus.wr_en)      m_flags = bus.wr_data;
    else if (bus.load_flags) m_flags = (m_flags & ~bus.flag_mask) | (bus.flags_in & bus.flag_mask);
    if (do_push) m_stk.push_back(old);
    if ((bus.push || bus.pop) && !do_push && !do_pop) m_err = 1;
    else if (bus.err_clr) m_err = 0;
`ifdef FLAGS_CTX_STICKY_EN
    if (bus.sticky_clr) m_sticky = '0;
    if (bus.load_flags) m_sticky = m_sticky | (bus.flag_mask & bus.flags_in);
`endif
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("flags", 32'(bus.flags), 32'(m_flags));
    check("depth", 32'(bus.depth), m_stk.size());
    check("full",  32'(bus.stack_full),  32'(m_stk.size() == SD));
    check("empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
    check("err",   32'(bus.stack_err),   32'(m_err));
`ifdef FLAGS_CTX_STICKY_EN
    check("sticky", 32'(bus.sticky), 32'(m_sticky));
`endif
    idle();
  endtask

  task automatic wr(input logic [NF-1:0] v);
    bus.wr_en = 1'b1; bus.wr_data = v; step();
  endtask

  task automatic do_push();
    bus.push = 1'b1; step();
  endtask

  task automatic do_pop();
    bus.pop = 1'b1; step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_empty", 32'(bus.stack_empty), 32'h1);

    // Reset while contexts are stacked and a push is requested.
    for (int i = 0; i < 3; i++) begin
      wr(NF'(i + 5));
      do_push();
    end
    reset = 1'b1; bus.push = 1'b1; step();
    check("midrst_flags", 32'(bus.flags), 32'h0);
    check("midrst_depth", 32'(bus.depth), 32'h0);
    check("midrst_err",   32'(bus.stack_err), 32'h0);

    // Masked load then all-zero mask.
    bus.load_flags = 1'b1; bus.flags_in = 4'b1111; bus.flag_mask = 4'b0101; step();
    check("mask_load", 32'(bus.flags), 32'b0101);
    bus.load_flags = 1'b1; bus.flags_in = 4'b1010; bus.flag_mask = 4'b0000; step();
    check("mask_hold", 32'(bus.flags), 32'b0101);

    // Push saves the pre-edge value while a same-cycle load still lands.
    wr(4'b0011);
    bus.push = 1'b1; bus.load_flags = 1'b1; bus.flags_in = 4'b1100; bus.flag_mask = 4'b1111; step();
    check("push_load_flags", 32'(bus.flags), 32'b1100);
    check("push_load_depth", 32'(bus.depth), 32'h1);
    do_pop();
    check("pop_restore", 32'(bus.flags), 32'b0011);

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < SD; i++) begin
      wr(NF'(1 << i));
      do_push();
    end
    check("fill_full", 32'(bus.stack_full), 32'h1);
    do_push();
    check("ovf_depth", 32'(bus.depth), 32'(SD));
    check("ovf_err",   32'(bus.stack_err), 32'h1);
    wr(4'b0000);
    for (int i = SD - 1; i >= 0; i--) begin
      do_pop();
      check("drain", 32'(bus.flags), 32'(1 << i));
    end
    do_pop();
    check("udf_flags", 32'(bus.flags), 32'b0001);
    check("udf_empty", 32'(bus.stack_empty), 32'h1);
    check("udf_err",   32'(bus.stack_err), 32'h1);

    // Pop beats wr_en; simultaneous push/pop; err_clr versus a new error.
    bus.err_clr = 1'b1; step();
    wr(4'b1010);
    do_push();
    wr(4'b0110);
    bus.pop = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 4'b1111; step();
    check("pop_over_wr", 32'(bus.flags), 32'b1010);
    do_push();
    bus.push = 1'b1; bus.pop = 1'b1; step();
    check("pushpop_depth", 32'(bus.depth), 32'h1);
    check("pushpop_err",   32'(bus.stack_err), 32'h1);
    bus.err_clr = 1'b1; step();
    check("errclr", 32'(bus.stack_err), 32'h0);
    do_pop();
    bus.err_clr = 1'b1; bus.pop = 1'b1; step();
    check("errclr_vs_set", 32'(bus.stack_err), 32'h1);

`ifdef FLAGS_CTX_STICKY_EN
    bus.sticky_clr = 1'b1; step();
    bus.load_flags = 1'b1; bus.flags_in = 4'b0100; bus.flag_mask = 4'b1111; step();
    bus.load_flags = 1'b1; bus.flags_in = 4'b0000; bus.flag_mask = 4'b1111; step();
    check("sticky_flags", 32'(bus.flags), 32'h0);
    check("sticky_hold",  32'(bus.sticky), 32'b0100);
    bus.sticky_clr = 1'b1; step();
    check("sticky_clr", 32'(bus.sticky), 32'h0);
`endif

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.load_flags = 1'($urandom_range(0, 1));
      bus.flag_mask  = NF'($urandom);
      bus.flags_in   = NF'($urandom);
      bus.wr_en      = ($urandom_range(0, 3) == 0);
      bus.wr_data    = NF'($urandom);
      bus.push       = ($urandom_range(0, 2) == 0);
      bus.pop        = ($urandom_range(0, 2) == 0);
      bus.err_clr    = ($urandom_range(0, 7) == 0);
`ifdef FLAGS_CTX_STICKY_EN
      bus.sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
